// File: rtl/mul_seq.sv
// Sequential shift-add / radix-2 Booth multiplier: one iteration per clock,
// operands latched on acceptance, single-cycle done pulse with busy flag.
module mul_seq #(
  parameter int         WIDTH       = 16,
  parameter logic [3:0] DT_UNSIGNED = 4'h2,
  parameter logic [3:0] DT_SIGNED   = 4'h3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  input  logic                 start,
  input  logic [3:0]           dtype,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  // Handshake: start is a level request honoured only in IDLE with a supported
  // dtype; busy is high from the accepting edge until DONE ends; done is a
  // one-cycle pulse during which result already holds the new product.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       a_q, a_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 signed_q, signed_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, done_q;

  logic [WIDTH:0]       m_ext, a_in, sum;
  logic [WIDTH:0]       a_it;
  logic [WIDTH-1:0]     q_it;
  logic                 qm1_it;

  // One iteration; the guard bit of A keeps -2^(WIDTH-1) subtraction exact.
  always_comb begin
    m_ext = signed_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    a_in  = signed_q ? a_q : {1'b0, a_q[WIDTH-1:0]};
    sum   = a_in;
    if (signed_q) begin
      case ({q_q[0], qm1_q})
        2'b01:   sum = a_in + m_ext;
        2'b10:   sum = a_in - m_ext;
        default: sum = a_in;
      endcase
    end else if (q_q[0]) begin
      sum = a_in + m_ext;
    end
    a_it   = {signed_q & sum[WIDTH], sum[WIDTH:1]};
    q_it   = {sum[0], q_q[WIDTH-1:1]};
    qm1_it = q_q[0];
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    a_d      = a_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && (dtype == DT_UNSIGNED || dtype == DT_SIGNED)) begin
          m_d      = M;
          q_d      = Q;
          signed_d = (dtype == DT_SIGNED);
          a_d      = '0;
          qm1_d    = 1'b0;
          cnt_d    = CW'(WIDTH);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_it;
        q_d   = q_it;
        qm1_d = qm1_it;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = {a_it[WIDTH-1:0], q_it};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      a_q      <= a_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      result_q <= result_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
